// File: rtl/elevator_scan_ctrl.sv
// SCAN-order single-car elevator controller with timed floor travel and a timed door.
// Optional return-to-home after idling is compiled in with ELEVATOR_HOME_RETURN_EN.
module elevator_scan_ctrl #(
    parameter int unsigned FLOORS        = 8,
    parameter int unsigned POS_W         = 3,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
`ifdef ELEVATOR_HOME_RETURN_EN
    ,
    parameter int unsigned HOME_FLOOR    = 0,
    parameter int unsigned IDLE_CYCLES   = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLOORS-1:0] floor_req,
    input  logic              door_hold,
    output logic [POS_W-1:0]  floor_pos,
    output logic              door_open,
    output logic              moving_up,
    output logic              moving_down,
    output logic [FLOORS-1:0] pending_req,
    output logic              arrived
);
    localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

    state_t            state, state_n;
    logic              dir, dir_n;
    logic [POS_W-1:0]  pos_n, step_pos;
    logic [TW-1:0]     travel_cnt, travel_n;
    logic [DW-1:0]     door_cnt, door_n;
    logic              arrived_n;
    logic [FLOORS-1:0] served, cur_bit, new_bit;
    logic              ahead_here, behind_here, ahead_new;

`ifdef ELEVATOR_HOME_RETURN_EN
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0]     idle_cnt, idle_n;
    logic              home_act, home_n;
`endif

    function automatic logic [FLOORS-1:0] bit_of(input logic [POS_W-1:0] p);
        return {{(FLOORS-1){1'b0}}, 1'b1} << p;
    endfunction

    // Floors strictly above (up=1) or strictly below (up=0) position p.
    function automatic logic [FLOORS-1:0] dir_mask(input logic [POS_W-1:0] p, input logic up);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < FLOORS; i++)
            m[i] = up ? (i > 32'(p)) : (i < 32'(p));
        return m;
    endfunction

    always_comb begin
        state_n     = state;
        dir_n       = dir;
        pos_n       = floor_pos;
        travel_n    = travel_cnt;
        door_n      = door_cnt;
        arrived_n   = 1'b0;
        served      = '0;
        cur_bit     = bit_of(floor_pos);
        step_pos    = dir ? floor_pos + POS_W'(1) : floor_pos - POS_W'(1);
        new_bit     = bit_of(step_pos);
        ahead_here  = |(pending_req & dir_mask(floor_pos, dir));
        behind_here = |(pending_req & dir_mask(floor_pos, ~dir));
        ahead_new   = |(pending_req & dir_mask(step_pos, dir));
`ifdef ELEVATOR_HOME_RETURN_EN
        idle_n      = '0;
        home_n      = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // A press at the parked floor opens the door on capture, never latching.
                if (|((pending_req | floor_req) & cur_bit)) begin
                    served  = cur_bit;
                    state_n = S_DOOR;
                    door_n  = DW'(DOOR_CYCLES);
                end else if (ahead_here) begin
                    state_n  = S_MOVE;
                    travel_n = TW'(TRAVEL_CYCLES);
                end else if (behind_here) begin
                    dir_n    = ~dir;
                    state_n  = S_MOVE;
                    travel_n = TW'(TRAVEL_CYCLES);
                end
`ifdef ELEVATOR_HOME_RETURN_EN
                else if (floor_pos != POS_W'(HOME_FLOOR)) begin
                    if (idle_cnt == IW'(IDLE_CYCLES)) begin
                        dir_n    = (floor_pos < POS_W'(HOME_FLOOR));
                        state_n  = S_MOVE;
                        travel_n = TW'(TRAVEL_CYCLES);
                        home_n   = 1'b1;
                    end else begin
                        idle_n = idle_cnt + IW'(1);
                    end
                end
`endif
            end
            S_MOVE: begin
`ifdef ELEVATOR_HOME_RETURN_EN
                home_n = home_act;
`endif
                if (travel_cnt == TW'(1)) begin
                    pos_n     = step_pos;
                    arrived_n = 1'b1;
                    travel_n  = '0;
`ifdef ELEVATOR_HOME_RETURN_EN
                    home_n = home_act && (pending_req == '0) && (step_pos != POS_W'(HOME_FLOOR));
`endif
                    if (|(pending_req & new_bit)) begin
                        served  = new_bit;
                        state_n = S_DOOR;
                        door_n  = DW'(DOOR_CYCLES);
                    end else if (ahead_new) begin
                        travel_n = TW'(TRAVEL_CYCLES);
                    end
`ifdef ELEVATOR_HOME_RETURN_EN
                    else if (home_n) begin
                        travel_n = TW'(TRAVEL_CYCLES);
                    end
`endif
                    else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    travel_n = travel_cnt - TW'(1);
                end
            end
            S_DOOR: begin
                served = cur_bit;
                if (door_hold || |(floor_req & cur_bit)) begin
                    door_n = DW'(DOOR_CYCLES);
                end else if (door_cnt <= DW'(1)) begin
                    state_n = S_IDLE;
                    door_n  = '0;
                end else begin
                    door_n = door_cnt - DW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dir         <= 1'b1;
            floor_pos   <= '0;
            pending_req <= '0;
            travel_cnt  <= '0;
            door_cnt    <= '0;
            arrived     <= 1'b0;
`ifdef ELEVATOR_HOME_RETURN_EN
            idle_cnt    <= '0;
            home_act    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            dir         <= dir_n;
            floor_pos   <= pos_n;
            pending_req <= (pending_req | floor_req) & ~served;
            travel_cnt  <= travel_n;
            door_cnt    <= door_n;
            arrived     <= arrived_n;
`ifdef ELEVATOR_HOME_RETURN_EN
            idle_cnt    <= idle_n;
            home_act    <= home_n;
`endif
        end
    end

    assign door_open   = (state == S_DOOR);
    assign moving_up   = (state == S_MOVE) && dir;
    assign moving_down = (state == S_MOVE) && !dir;

    // Moves only start toward a pending floor, so the car can never step past an end floor.
    assert property (@(posedge clk) disable iff (!rst_n)
        (state == S_MOVE && travel_cnt == TW'(1)) |->
            (dir ? (32'(floor_pos) < FLOORS - 1) : (floor_pos != '0)));

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: directed scenarios plus random requests
// against a floor-level behavioural model.
module tb_elevator_scan_ctrl;
    localparam int FL = 8;
    localparam int PW = 3;
    localparam int TC = 4;
    localparam int DC = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_MOVE = 1;
    localparam int PH_DOOR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FL-1:0] floor_req = '0;
    logic          door_hold = 1'b0;
    logic [PW-1:0] floor_pos;
    logic          door_open, moving_up, moving_down, arrived;
    logic [FL-1:0] pending_req;

    elevator_scan_ctrl #(
        .FLOORS(FL), .POS_W(PW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .floor_req(floor_req), .door_hold(door_hold),
        .floor_pos(floor_pos), .door_open(door_open), .moving_up(moving_up),
        .moving_down(moving_down), .pending_req(pending_req), .arrived(arrived)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int            pos;
        logic          dopen;
        logic          up;
        logic          dn;
        logic          arr;
        logic [FL-1:0] pend;
    } exp_t;
    exp_t q[$];

    // Reference model: floor, travel direction, outstanding floors, phase and its timer.
    int            m_pos;
    bit            m_dir;
    logic [FL-1:0] m_pend;
    int            m_ph;
    int            m_tmr;
    bit            m_arr;

    task automatic model_reset();
        m_pos = 0; m_dir = 1'b1; m_pend = '0; m_ph = PH_IDLE; m_tmr = 0; m_arr = 1'b0;
    endtask

    function automatic bit any_beyond(input int from, input bit up, input logic [FL-1:0] p);
        for (int f = 0; f < FL; f++)
            if (p[f] && (up ? (f > from) : (f < from))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic [FL-1:0] req, input bit hold);
        logic [FL-1:0] seen;
        logic [FL-1:0] grab;
        seen  = m_pend;
        grab  = m_pend | req;
        m_arr = 1'b0;
        case (m_ph)
            PH_IDLE: begin
                if (seen[m_pos] || req[m_pos]) begin
                    grab[m_pos] = 1'b0; m_ph = PH_DOOR; m_tmr = DC;
                end else if (any_beyond(m_pos, m_dir, seen)) begin
                    m_ph = PH_MOVE; m_tmr = TC;
                end else if (any_beyond(m_pos, !m_dir, seen)) begin
                    m_dir = !m_dir; m_ph = PH_MOVE; m_tmr = TC;
                end
            end
            PH_MOVE: begin
                m_tmr--;
                if (m_tmr == 0) begin
                    m_pos = m_dir ? m_pos + 1 : m_pos - 1;
                    m_arr = 1'b1;
                    if (seen[m_pos]) begin
                        grab[m_pos] = 1'b0; m_ph = PH_DOOR; m_tmr = DC;
                    end else if (any_beyond(m_pos, m_dir, seen)) begin
                        m_tmr = TC;
                    end else begin
                        m_ph = PH_IDLE;
                    end
                end
            end
            default: begin
                grab[m_pos] = 1'b0;
                if (hold || req[m_pos]) begin
                    m_tmr = DC;
                end else begin
                    m_tmr--;
                    if (m_tmr == 0) m_ph = PH_IDLE;
                end
            end
        endcase
        m_pend = grab;
    endtask

    // Monitor: every cycle the DUT presents its outputs, compared at the falling edge.
    bit mon_en = 1'b0;
    int c_door = 0, c_up = 0, c_dn = 0, c_arr = 0, c_pnz = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (door_open)    c_door++;
                if (moving_up)    c_up++;
                if (moving_down)  c_dn++;
                if (arrived)      c_arr++;
                if (pending_req != '0) c_pnz++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("floor_pos",   int'(floor_pos),   e.pos);
                    chk("door_open",   int'(door_open),   int'(e.dopen));
                    chk("moving_up",   int'(moving_up),   int'(e.up));
                    chk("moving_down", int'(moving_down), int'(e.dn));
                    chk("arrived",     int'(arrived),     int'(e.arr));
                    chk("pending_req", int'(pending_req), int'(e.pend));
                end
            end
        end
    end

    task automatic cyc(input logic [FL-1:0] req, input bit hold);
        exp_t e;
        @(negedge clk); #1;
        floor_req = req;
        door_hold = hold;
        model_step(req, hold);
        e.pos = m_pos; e.dopen = (m_ph == PH_DOOR);
        e.up = (m_ph == PH_MOVE) && m_dir; e.dn = (m_ph == PH_MOVE) && !m_dir;
        e.arr = m_arr; e.pend = m_pend;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc('0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pos"},  int'(floor_pos),   0);
        chk({tag, "_door"}, int'(door_open),   0);
        chk({tag, "_up"},   int'(moving_up),   0);
        chk({tag, "_dn"},   int'(moving_down), 0);
        chk({tag, "_arr"},  int'(arrived),     0);
        chk({tag, "_pend"}, int'(pending_req), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_door, s_up, s_dn, s_arr, s_pnz;
        logic [FL-1:0] r;

        model_reset();
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Request at the parked floor: door only, nothing latched.
        s_door = c_door; s_up = c_up; s_dn = c_dn; s_pnz = c_pnz;
        cyc(8'h01, 1'b0); idle(8);
        chk("t1_door_cycles", c_door - s_door, 3);
        chk("t1_moving", (c_up - s_up) + (c_dn - s_dn), 0);
        chk("t1_pending_seen", c_pnz - s_pnz, 0);

        // Ground to floor 3.
        s_door = c_door; s_up = c_up; s_arr = c_arr;
        cyc(8'h08, 1'b0); idle(25);
        chk("t2_up_cycles", c_up - s_up, 12);
        chk("t2_arrivals", c_arr - s_arr, 3);
        chk("t2_door_cycles", c_door - s_door, 3);
        chk("t2_floor", int'(floor_pos), 3);
        chk("t2_pending", int'(pending_req), 0);

        // Requests on both sides: up first to 5, then back down to 1.
        s_door = c_door; s_arr = c_arr; s_up = c_up; s_dn = c_dn;
        cyc(8'h22, 1'b0); idle(60);
        chk("t3_door_cycles", c_door - s_door, 6);
        chk("t3_arrivals", c_arr - s_arr, 6);
        chk("t3_up_cycles", c_up - s_up, 8);
        chk("t3_dn_cycles", c_dn - s_dn, 16);
        chk("t3_floor", int'(floor_pos), 1);

        // Back to ground, then 0->5 with floor 4 inserted between floors 2 and 3.
        cyc(8'h01, 1'b0); idle(15);
        chk("t4_start_floor", int'(floor_pos), 0);
        s_door = c_door; s_arr = c_arr;
        cyc(8'h20, 1'b0); idle(10);
        cyc(8'h10, 1'b0); idle(40);
        chk("t4_door_cycles", c_door - s_door, 6);
        chk("t4_arrivals", c_arr - s_arr, 5);
        chk("t4_floor", int'(floor_pos), 5);

        // Door hold for 10 cycles, then a same-floor press reloads the timer.
        s_door = c_door; s_pnz = c_pnz;
        cyc(8'h20, 1'b0);
        repeat (10) cyc('0, 1'b1);
        cyc('0, 1'b0);
        cyc(8'h20, 1'b0);
        idle(10);
        chk("t5_door_cycles", c_door - s_door, 15);
        chk("t5_pending_seen", c_pnz - s_pnz, 0);

        // Asynchronous reset while moving down past floor 2.
        cyc(8'h01, 1'b0); idle(14);
        @(negedge clk); #1;
        mon_en = 1'b0;
        chk("t6_pre_floor", int'(floor_pos), 2);
        chk("t6_pre_down", int'(moving_down), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        floor_req = 8'hFF;
        repeat (3) @(negedge clk);
        chk_all_zero("t6_held");
        #1;
        floor_req = '0;
        rst_n = 1'b1;
        model_reset();
        q.delete();
        mon_en = 1'b1;
        cyc(8'h04, 1'b0); idle(20);
        chk("t6_after_floor", int'(floor_pos), 2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      r = 8'(1) << $urandom_range(0, FL - 1);
            else if (sel == 1) r = 8'($urandom);
            else               r = '0;
            cyc(r, ($urandom_range(0, 19) == 0));
        end
        idle(150);
        chk("final_pending", int'(pending_req), 0);

        @(negedge clk); #1;
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised successor to the single-car elevator controller.
- Latches floor requests into a pending mask and serves them in SCAN order: it keeps its direction while requests remain ahead, then reverses.
- Models finite travel time per floor and a timed door with a hold input.
- Sits between the floor-button decoder and the car motor/door drivers.

Parameters:
- FLOORS, 8, number of floors (at least 2); floor index 0 is the ground floor.
- POS_W, 3, width of floor_pos; must be at least clog2(FLOORS).
- TRAVEL_CYCLES, 4, clock cycles to move one floor (at least 1).
- DOOR_CYCLES, 3, clock cycles the door stays open after its last (re)start (at least 1).

Ports:
- clk, input, 1, system clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- floor_req, input, FLOORS, one-hot or multi-hot request pulses; bit i requests floor i.
- door_hold, input, 1, level input; while high in DOOR, the door timer is reloaded.
- floor_pos, output, POS_W, current car floor.
- door_open, output, 1, high in DOOR state.
- moving_up, output, 1, high in MOVE state with direction up.
- moving_down, output, 1, high in MOVE state with direction down.
- pending_req, output, FLOORS, latched, not-yet-served requests.
- arrived, output, 1, one-cycle pulse on each floor step completion.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, floor_pos=0, dir=up, pending_req=0, travel and door counters=0. All outputs are 0 and stay 0 while rst_n is low.
- Request capture: each cycle, pending_req <= (pending_req | floor_req) & ~served_mask.
  - A request is visible to the FSM one cycle after its pulse.
  - Repeat presses of an already-pending floor have no effect.
- Direction outputs: dir is a register retained across IDLE and DOOR; moving_up/moving_down are derived from it in MOVE only.
- IDLE, evaluated on pending_req:
  - If bit floor_pos is set: clear it, go to DOOR, load door counter with DOOR_CYCLES.
  - Else, if a request exists ahead in dir: go to MOVE in dir.
  - Else, if a request exists behind: flip dir, go to MOVE.
  - Else: stay in IDLE.
- MOVE:
  - The travel counter counts TRAVEL_CYCLES cycles. On the last cycle, floor_pos steps by ±1 and arrived pulses.
  - At the new floor, if its bit is pending: clear it, go to DOOR.
  - Else, if requests remain ahead: stay in MOVE with the counter reloaded.
  - Else: go to IDLE.
  - floor_pos never leaves 0..FLOORS-1; a step beyond the end floor is impossible by construction and must be asserted in simulation.
- Request for floor_pos during MOVE: the car has already departed, so the bit is latched and served on a later pass.
- DOOR:
  - door_open=1. The door counter decrements each cycle; door_hold=1 reloads it to DOOR_CYCLES.
  - A new request for floor_pos arriving in DOOR is cleared on capture (never appears in pending_req) and reloads the counter.
  - When the counter expires with door_hold=0: go to IDLE, door_open=0.
  - Minimum door open time is DOOR_CYCLES cycles.
- Movement never starts in the same cycle the door closes; IDLE always lasts at least one cycle.
- Simultaneous requests above and below while idle: the current dir wins (dir=up after reset).
- Reset mid-operation: immediate return to reset state; pending requests are discarded.

Optional Feature:
- Macro: ELEVATOR_HOME_RETURN_EN.
- When defined, adds parameters HOME_FLOOR (default 0) and IDLE_CYCLES (default 16).
  - An idle counter runs while in IDLE with pending_req=0 and floor_pos!=HOME_FLOOR.
  - When it reaches IDLE_CYCLES, the car moves toward HOME_FLOOR without opening the door on arrival.
  - Any new request during this move cancels the home target at the next floor step; normal SCAN resumes.
  - The idle counter clears on any non-IDLE state.
- When undefined: the car stays parked in IDLE indefinitely, with no extra logic or parameters.

Test Plan:
- Reset then pulse floor_req bit 0 at floor 0: door_open high exactly 3 cycles starting 1 cycle after the pulse; moving_up/moving_down stay 0; pending_req stays 0.
- From floor 0, pulse floor 3: moving_up for 12 cycles; floor_pos steps 1,2,3 every 4 cycles with arrived pulses; then door_open for 3 cycles; pending_req returns to 0.
- Idle at floor 3 with dir=up, pulse floors 1 and 5 in the same cycle: car goes up to 5 and opens, then reverses down to 1 and opens; pending_req goes 0x22 → 0x02 → 0x00.
- Moving 0→5 with the car between floors 2 and 3, pulse floor 4: car stops and opens at 4, then continues to 5.
- In DOOR, hold door_hold high for 10 cycles: door_open lasts 10+3 cycles; a floor_pos request pulse mid-door reloads the timer and never appears in pending_req.
- Assert rst_n low mid-MOVE at floor 2: all outputs 0 and pending_req 0 immediately, without waiting for a clock edge; after release, floor_pos=0 and state IDLE.
